// File: rtl/flash_loader_if.sv
// Byte-stream input plus flash write bus of the program loader.
// Loader side uses the slave modport; the byte source / observer uses master.
interface flash_loader_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             flash_en;
    logic [WIDTH-1:0] flash_addr;
    logic [WIDTH-1:0] flash_data;
    logic             busy;
    logic             done;
    logic             error;
    logic [2:0]       dbg_state;

    modport slave (
        input  in_valid, in_data,
        output in_ready, flash_en, flash_addr, flash_data, busy, done, error, dbg_state
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, flash_en, flash_addr, flash_data, busy, done, error, dbg_state
    );
endinterface

// File: rtl/flash_loader.sv
// Program loader: consumes "N (LE32), then N LE32 words" from a byte stream
// and issues one-cycle word writes to program memory.
module flash_loader #(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR      = '0,
    parameter int               MAX_WORDS      = 1024,
    parameter int               TIMEOUT_CYCLES = 1000000
) (
    input logic            clk,
    input logic            rst,
    flash_loader_if.slave  bus
);
    localparam int IDXW = $clog2(MAX_WORDS + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q;
    logic [1:0]       byte_cnt_q;
    logic [IDXW-1:0]  word_idx_q;
    logic [31:0]      len_q;
    logic [31:0]      shift_q;
    logic [TW-1:0]    tmo_q;
    logic             flash_en_q;
    logic [WIDTH-1:0] flash_addr_q;
    logic [WIDTH-1:0] flash_data_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    logic             accept;
    logic             last_byte;
    logic [31:0]      len_d;
    logic [31:0]      shift_d;
    logic [IDXW-1:0]  word_idx_d;
    logic [TW-1:0]    tmo_d;
    logic             tmo_hit;
    logic [WIDTH-1:0] addr_d;

    // A byte moves when in_valid && in_ready at a rising edge; in_ready is a
    // function of state alone and never looks at in_valid.
    assign bus.in_ready = (state_q == S_IDLE) || (state_q == S_LEN) || (state_q == S_DATA);
    assign accept       = bus.in_valid && bus.in_ready;

    // Bytes shift in from the top so the first byte lands in bits 7:0.
    assign len_d      = {bus.in_data, len_q[31:8]};
    assign shift_d    = {bus.in_data, shift_q[31:8]};
    assign last_byte  = (byte_cnt_q == 2'd3);
    assign word_idx_d = word_idx_q + IDXW'(1);
    assign tmo_d      = tmo_q + TW'(1);
    assign tmo_hit    = (tmo_d == TW'(TIMEOUT_CYCLES));
    assign addr_d     = BASE_ADDR + WIDTH'({word_idx_q, 2'b00});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            len_q        <= '0;
            shift_q      <= '0;
            tmo_q        <= '0;
            flash_en_q   <= 1'b0;
            flash_addr_q <= '0;
            flash_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            flash_en_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q    <= S_LEN;
                        len_q      <= len_d;
                        byte_cnt_q <= 2'd1;
                        tmo_q      <= '0;
                        error_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        len_q      <= len_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        tmo_q      <= '0;
                        if (last_byte) begin
                            if (len_d == 32'd0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else if (len_d > 32'(MAX_WORDS)) begin
                                state_q <= S_IDLE;
                                error_q <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q    <= S_DATA;
                                word_idx_q <= '0;
                            end
                        end
                    end else if (tmo_hit) begin
                        state_q <= S_IDLE;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        shift_q    <= shift_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        tmo_q      <= '0;
                        if (last_byte) begin
                            state_q      <= S_WRITE;
                            flash_en_q   <= 1'b1;
                            flash_addr_q <= addr_d;
                            flash_data_q <= WIDTH'(shift_d);
                        end
                    end else if (tmo_hit) begin
                        state_q    <= S_IDLE;
                        error_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        byte_cnt_q <= '0;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_WRITE: begin
                    word_idx_q <= word_idx_d;
                    tmo_q      <= '0;
                    if (32'(word_idx_d) == len_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_DATA;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flash_en   = flash_en_q;
    assign bus.flash_addr = flash_addr_q;
    assign bus.flash_data = flash_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_flash_loader.sv
// Scoreboarded bench for flash_loader: instance A (base 0) and instance B
// (base 0xFFFFFFFC), both with an 8-cycle timeout.
module tb_flash_loader;
    logic clk;
    logic rst;
    logic drv_valid;
    logic [7:0] drv_data;
    logic sel;

    int vectors;
    int miscompares;
    int done_a;
    int done_b;
    logic prev_busy_a;
    logic prev_busy_b;
    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];

    flash_loader_if #(.WIDTH(32)) bus_a ();
    flash_loader_if #(.WIDTH(32)) bus_b ();

    assign bus_a.in_valid = drv_valid && !sel;
    assign bus_b.in_valid = drv_valid && sel;
    assign bus_a.in_data  = drv_data;
    assign bus_b.in_data  = drv_data;

    flash_loader #(
        .WIDTH(32), .BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024), .TIMEOUT_CYCLES(8)
    ) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    flash_loader #(
        .WIDTH(32), .BASE_ADDR(32'hFFFF_FFFC), .MAX_WORDS(1024), .TIMEOUT_CYCLES(8)
    ) u_dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver tasks: called at posedge+1, return at posedge+1 after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        logic ok;
        for (int i = 0; i < gap; i++) begin
            drv_valid = 1'b0;
            @(posedge clk); #1;
        end
        drv_valid = 1'b1;
        drv_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            r = sel ? bus_b.in_ready : bus_a.in_ready;
            @(posedge clk); #1;
            ok = r;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_bound: byte %h not accepted within 64 cycles", b);
        end
    endtask

    task automatic idle(input int n);
        drv_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_seq(input logic [7:0] bytes[$], input int max_gap);
        foreach (bytes[i]) send_byte(bytes[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
        idle(1);
    endtask

    task automatic wait_done(input logic which, input int target);
        int cnt;
        cnt = which ? done_b : done_a;
        for (int t = 0; t < 32 && cnt < target; t++) begin
            @(posedge clk); #1;
            cnt = which ? done_b : done_a;
        end
        chk(which ? "done_count_b" : "done_count_a", 64'(cnt), 64'(target));
    endtask

    // Scoreboard monitors: pop on every flash_en, check busy falls as done rises.
    initial begin
        prev_busy_a = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus_a.flash_en) begin
                    if (exp_a.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write_a: got addr %h data %h expected no write",
                                 bus_a.flash_addr, bus_a.flash_data);
                    end else begin
                        chk("write_a", {bus_a.flash_addr, bus_a.flash_data}, exp_a.pop_front());
                    end
                end
                if (bus_a.done) begin
                    done_a++;
                    chk("busy_fall_a", {62'd0, prev_busy_a, bus_a.busy}, 64'd2);
                end
            end
            prev_busy_a = bus_a.busy;
        end
    end

    initial begin
        prev_busy_b = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus_b.flash_en) begin
                    if (exp_b.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write_b: got addr %h data %h expected no write",
                                 bus_b.flash_addr, bus_b.flash_data);
                    end else begin
                        chk("write_b", {bus_b.flash_addr, bus_b.flash_data}, exp_b.pop_front());
                    end
                end
                if (bus_b.done) begin
                    done_b++;
                    chk("busy_fall_b", {62'd0, prev_busy_b, bus_b.busy}, 64'd2);
                end
            end
            prev_busy_b = bus_b.busy;
        end
    end

    // Directed stimulus
    initial begin
        logic [7:0] seq[$];
        vectors     = 0;
        miscompares = 0;
        done_a      = 0;
        done_b      = 0;
        rst         = 1'b0;
        drv_valid   = 1'b0;
        drv_data    = 8'h00;
        sel         = 1'b0;

        #2;
        chk("rst_flash_en",   64'(bus_a.flash_en),   64'd0);
        chk("rst_flash_addr", 64'(bus_a.flash_addr), 64'd0);
        chk("rst_flash_data", 64'(bus_a.flash_data), 64'd0);
        chk("rst_busy_done_error", {61'd0, bus_a.busy, bus_a.done, bus_a.error}, 64'd0);
        chk("rst_state",      64'(bus_a.dbg_state),  64'd0);
        chk("rst_in_ready",   64'(bus_a.in_ready),   64'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Two-word load, back to back, with the write-latency check on word 0.
        exp_a.push_back({32'h0000_0000, 32'h0000_0013});
        exp_a.push_back({32'h0000_0004, 32'h0010_0093});
        seq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00};
        foreach (seq[i]) send_byte(seq[i], 0);
        send_byte(8'h00, 0);
        chk("latency_flash_en", {31'd0, bus_a.flash_en, bus_a.flash_addr}, {31'd0, 1'b1, 32'h0});
        seq = '{8'h93, 8'h00, 8'h10, 8'h00};
        send_seq(seq, 0);
        wait_done(1'b0, 1);
        chk("t1_error", 64'(bus_a.error), 64'd0);
        chk("t1_queue_empty", 64'(exp_a.size()), 64'd0);

        // Zero-length load: done on the cycle after the 4th count byte.
        seq = '{8'h00, 8'h00, 8'h00};
        foreach (seq[i]) send_byte(seq[i], 0);
        send_byte(8'h00, 0);
        chk("n0_done_next_cycle", {62'd0, bus_a.done, bus_a.busy}, 64'd2);
        idle(3);
        wait_done(1'b0, 2);

        // Address wrap on instance B.
        sel = 1'b1;
        exp_b.push_back({32'hFFFF_FFFC, 32'h1122_3344});
        exp_b.push_back({32'h0000_0000, 32'h5566_7788});
        seq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                8'h88, 8'h77, 8'h66, 8'h55};
        send_seq(seq, 0);
        wait_done(1'b1, 1);
        chk("wrap_queue_empty", 64'(exp_b.size()), 64'd0);
        sel = 1'b0;
        idle(2);

        // Timeout: N=1, two data bytes, then silence.
        seq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA};
        foreach (seq[i]) send_byte(seq[i], 0);
        send_byte(8'hBB, 0);
        idle(7);
        chk("tmo_not_yet", {62'd0, bus_a.error, bus_a.busy}, 64'd1);
        idle(1);
        chk("tmo_error_busy", {62'd0, bus_a.error, bus_a.busy}, 64'd2);
        chk("tmo_state_idle", 64'(bus_a.dbg_state), 64'd0);
        send_byte(8'h00, 0);
        chk("tmo_error_clears", {62'd0, bus_a.error, bus_a.busy}, 64'd1);
        seq = '{8'h00, 8'h00, 8'h00};
        send_seq(seq, 0);
        wait_done(1'b0, 3);

        // Oversized count 0x401.
        seq = '{8'h01, 8'h04, 8'h00};
        foreach (seq[i]) send_byte(seq[i], 0);
        send_byte(8'h00, 0);
        chk("max_error", {61'd0, bus_a.error, bus_a.busy, bus_a.done}, 64'd4);
        chk("max_state_idle", 64'(bus_a.dbg_state), 64'd0);
        idle(4);

        // Same two-word load as the first case, with random gaps under the timeout.
        exp_a.push_back({32'h0000_0000, 32'h0000_0013});
        exp_a.push_back({32'h0000_0004, 32'h0010_0093});
        seq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00};
        send_seq(seq, 5);
        wait_done(1'b0, 4);
        chk("gaps_error", 64'(bus_a.error), 64'd0);
        chk("gaps_queue_empty", 64'(exp_a.size()), 64'd0);

        // Reset during word 1, then a fresh single-word load.
        exp_a.push_back({32'h0000_0000, 32'hDEAD_BEEF});
        seq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01};
        foreach (seq[i]) send_byte(seq[i], 0);
        send_byte(8'h02, 0);
        drv_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_outputs", {bus_a.flash_addr, bus_a.flash_data}, 64'd0);
        chk("arst_flags", {60'd0, bus_a.flash_en, bus_a.busy, bus_a.done, bus_a.error}, 64'd0);
        chk("arst_state", 64'(bus_a.dbg_state), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        idle(2);
        exp_a.push_back({32'h0000_0000, 32'h0BAD_F00D});
        seq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
        send_seq(seq, 0);
        wait_done(1'b0, 5);

        idle(4);
        chk("final_queue_a", 64'(exp_a.size()), 64'd0);
        chk("final_queue_b", 64'(exp_b.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/flash_loader.md
Name: flash_loader

Overview:
- Initiator side of the CPU program-load interface: turns an incoming byte stream into word writes on flash_en / flash_addr / flash_data.
- Sits between a byte source (UART receiver or testbench) and the top-level flash_* inputs.
- busy keeps the core held off while program memory is rewritten.
- Stream format: 4-byte word count N, then N words. All multi-byte fields are little-endian: first byte goes to bits 7:0.

Parameters:
WIDTH, 32, flash address/data width; must be 32 (4 bytes per word)
BASE_ADDR, 0, byte address of word 0
MAX_WORDS, 1024, largest legal N
TIMEOUT_CYCLES, 1000000, idle cycles tolerated mid-transfer before abort

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  reset, asynchronous assert, active-low (0 = reset)
in_valid  input  1  byte available
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte; transfer occurs when in_valid && in_ready at a rising edge
flash_en  output  1  one-cycle write strobe to program memory
flash_addr  output  WIDTH  byte address of write
flash_data  output  WIDTH  write data
busy  output  1  transfer in progress (LEN after first byte, DATA, WRITE)
done  output  1  one-cycle pulse: load completed
error  output  1  sticky: last transfer aborted

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; flash_en=0, flash_addr=0, flash_data=0, busy=0, done=0, error=0; byte, word and timeout counters =0. All outputs are registered except in_ready.
- in_ready is combinational from state only: 1 in IDLE/LEN/DATA, 0 in WRITE/DONE. It never depends on in_valid.
- IDLE:
  - Accepted byte → LEN; the byte is count byte 0; error clears.
  - No accepted byte → stay in IDLE.
- LEN:
  - Collect bytes 1..3 into N.
  - On the 4th byte: N==0 → DONE; N>MAX_WORDS → IDLE with error=1; otherwise → DATA with word index=0.
- DATA:
  - Collect 4 bytes into a shift register.
  - On the 4th accepted byte → WRITE.
- WRITE (exactly one cycle):
  - flash_en=1.
  - flash_addr = BASE_ADDR + 4*index, mod 2^WIDTH (wraps silently).
  - flash_data = the assembled word.
  - Then index+1: index+1==N → DONE, else → DATA.
- DONE (one cycle): done=1, then → IDLE.
- Latency: 4th byte of a word accepted at edge k → flash_en high for the cycle after edge k → earliest next byte accepted at edge k+2.
- flash_addr and flash_data hold their last written values until the next write. flash_en is 0 outside WRITE.
- Timeout:
  - Counter active in LEN and DATA only.
  - Increments every cycle without an accepted byte; clears on each accepted byte and on entering LEN/DATA.
  - Reaching TIMEOUT_CYCLES → IDLE, error=1, partial word discarded. Writes already issued are not undone.
- Extra bytes arriving in DONE are not accepted (in_ready=0). Bytes arriving after return to IDLE start a new transfer.
- Reset mid-transfer: immediate return to reset state; no further flash_en.
- Byte counter is 2 bits and wraps 3→0 on the 4th byte. The word index is wide enough for MAX_WORDS.

Test Plan:
- Bytes 02 00 00 00, 13 00 00 00, 93 00 10 00, in_valid held high → flash_en at addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093. done pulses once. busy falls the same cycle done rises. error=0.
- Count 00 00 00 00 → no flash_en; done pulses the cycle after the 4th byte.
- BASE_ADDR=0xFFFFFFFC, N=2 → writes at 0xFFFFFFFC then 0x00000000 (wrap).
- TIMEOUT_CYCLES=8: send count 1 plus 2 data bytes, then idle 8 cycles → error=1, state IDLE, no flash_en. The next accepted byte clears error.
- Count 0x00000401 with MAX_WORDS=1024 → error=1 after the 4th byte, no writes. Separately, random in_valid gaps shorter than the timeout → data and order identical to the back-to-back case.
- Deassert rst during DATA of word 1 → all outputs 0 asynchronously. After release, a fresh N=1 load writes address BASE_ADDR.
